// File: rtl/mem_arb.sv
// Arbiter between instruction fetch and data accesses for a single-port unified memory.
// Data wins contention unless fetch has been starved for STARVE_MAX consecutive data grants.
module mem_arb #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   starve_cnt, starve_nxt;
  logic               abort_q, abort_nxt;
  logic               mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt;
  logic               if_done_nxt, d_done_nxt;
  logic [DATA_W-1:0]  if_inst_nxt, d_rdata_nxt;

  logic starved, pick_if, pick_d, grant_if, grant_d;

  // The arbitration winner is chosen from the raw requests; a winner whose done is
  // pulsing this cycle is still holding a stale request, so no grant is issued then.
  always_comb begin
    starved  = (starve_cnt == CNT_W'(STARVE_MAX));
    pick_if  = if_req & (~d_req | starved);
    pick_d   = d_req & ~pick_if;
    grant_if = pick_if & ~if_done;
    grant_d  = pick_d & ~d_done;
  end

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    abort_nxt     = abort_q;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_done_nxt   = 1'b0;
    d_done_nxt    = 1'b0;
    if_inst_nxt   = if_inst;
    d_rdata_nxt   = d_rdata;

    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (grant_d) begin
          state_nxt     = BUSY_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
        end else if (grant_if) begin
          state_nxt     = BUSY_IF;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
        end
      end

      BUSY_IF: begin
        if (mem_rdy) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          starve_nxt  = '0;
          abort_nxt   = 1'b0;
          // A flushed fetch still finishes on the bus but its result is dropped.
          if (!(abort_q || if_abort)) begin
            if_inst_nxt = mem_rdata;
            if_done_nxt = 1'b1;
          end
        end else if (if_abort) begin
          abort_nxt = 1'b1;
        end
      end

      BUSY_D: begin
        if (mem_rdy) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          d_rdata_nxt = mem_rdata;
          d_done_nxt  = 1'b1;
          if (if_req) begin
            starve_nxt = starved ? starve_cnt : starve_cnt + CNT_W'(1);
          end else begin
            starve_nxt = '0;
          end
        end
      end

      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      abort_q    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_inst    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      abort_q    <= abort_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_done    <= if_done_nxt;
      d_done     <= d_done_nxt;
      if_inst    <= if_inst_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed stimulus pushes expected completions,
// a monitor pops them on each done pulse; a small memory model serves mem_req.
module tb_mem_arb;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_abort = 1'b0;
  logic              if_done;
  logic [DATA_W-1:0] if_inst;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdy = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_done(if_done), .if_inst(if_inst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          mem_w = 0;
  logic [31:0] mem_arr [0:511];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
  endtask

  task automatic push(input logic is_d, input logic chk, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.chk  = chk;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Returns at the falling edge of the cycle the selected done pulses.
  task automatic wait_done(input logic want_d, input int limit);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (want_d ? d_done : if_done) begin
        hit = 1'b1;
        break;
      end
    end
    check(want_d ? "d_done_wait" : "if_done_wait", 32'(hit), 32'd1);
  endtask

  task automatic run_abort(input int w, input int off, input logic [31:0] prev);
    cyc();
    if_req = 1'b1; if_addr = 9'h00C; mem_w = w;
    for (int c = 1; c <= w + 1; c++) begin
      cyc();
      if (c == off) begin if_abort = 1'b1; if_req = 1'b0; end
      else if_abort = 1'b0;
      smp();
      check("abort_mem_req_held", 32'(mem_req), 32'd1);
    end
    cyc();
    if_abort = 1'b0;
    smp();
    check("abort_mem_req_drop", 32'(mem_req), 32'd0);
    check("abort_no_if_done", 32'(if_done), 32'd0);
    check("abort_if_inst_kept", if_inst, prev);
  endtask

  // Memory model: mem_rdy after mem_w wait cycles, presented before the sampling edge.
  initial begin : memory_model
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        mem_rdy = 1'b0; mem_rdata = '0; wcnt = 0;
      end else if (mem_req) begin
        if (wcnt >= mem_w) begin
          mem_rdy = 1'b1;
          wcnt = 0;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            mem_rdata = '0;
          end else begin
            mem_rdata = mem_arr[mem_addr];
          end
        end else begin
          mem_rdy = 1'b0;
          wcnt++;
        end
      end else begin
        mem_rdy = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_done || d_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'({if_done, d_done}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 32'({if_done, d_done}), e.is_d ? 32'd1 : 32'd2);
          if (e.chk) check(e.is_d ? "d_rdata" : "if_inst", e.is_d ? d_rdata : if_inst, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < 512; i++) mem_arr[i] = 32'hA500_0000 | 32'(i);
    mem_arr[4]  = 32'h2002_000A;
    mem_arr[8]  = 32'h1111_0008;
    mem_arr[12] = 32'h0BAD_0BAD;
    mem_arr[32] = 32'hDEAD_BEEF;

    // Reset values
    repeat (2) smp();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_d_done", 32'(d_done), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    cyc();
    rst = 1'b0;

    // Lone fetch, W=0
    cyc();
    if_req = 1'b1; if_addr = 9'h004; mem_w = 0;
    push(1'b0, 1'b1, 32'h2002_000A);
    smp();
    check("lone_stall_n", 32'(stall), 32'd1);
    check("lone_mem_req_n", 32'(mem_req), 32'd0);
    cyc(); smp();
    check("lone_mem_req_n1", 32'(mem_req), 32'd1);
    check("lone_mem_addr", 32'(mem_addr), 32'h004);
    check("lone_stall_n1", 32'(stall), 32'd1);
    cyc(); smp();
    check("lone_if_done_n2", 32'(if_done), 32'd1);
    check("lone_stall_n2", 32'(stall), 32'd0);
    cyc();
    if_req = 1'b0;

    // Contention, W=2: data first, fetch in the IDLE cycle after d_done
    cyc();
    if_req = 1'b1; if_addr = 9'h008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; mem_w = 2;
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    push(1'b0, 1'b1, 32'h1111_0008);
    cyc(); smp();
    check("cont_first_req", 32'(mem_req), 32'd1);
    check("cont_first_addr", 32'(mem_addr), 32'h020);
    wait_done(1'b1, 20);
    cyc();
    d_req = 1'b0;
    smp();
    check("cont_idle_gap", 32'(mem_req), 32'd0);
    cyc(); smp();
    check("cont_fetch_req", 32'(mem_req), 32'd1);
    check("cont_fetch_addr", 32'(mem_addr), 32'h008);
    wait_done(1'b0, 20);
    cyc();
    if_req = 1'b0;

    // Store, W=1: bus fields latched at grant and held two cycles
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 32'h1234_5678; mem_w = 1;
    push(1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      cyc();
      d_wdata = 32'hFFFF_FFFF;
      smp();
      check("st_mem_req", 32'(mem_req), 32'd1);
      check("st_mem_we", 32'(mem_we), 32'd1);
      check("st_mem_addr", 32'(mem_addr), 32'h010);
      check("st_mem_wdata", mem_wdata, 32'h1234_5678);
      check("st_no_early_done", 32'(d_done), 32'd0);
    end
    cyc(); smp();
    check("st_d_done", 32'(d_done), 32'd1);
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    check("st_mem_written", mem_arr[16], 32'h1234_5678);

    // Abort during wait cycles, then abort+new request in IDLE is a fresh fetch
    run_abort(3, 2, 32'h1111_0008);
    cyc();
    if_req = 1'b1; if_addr = 9'h004; if_abort = 1'b1; mem_w = 0;
    push(1'b0, 1'b1, 32'h2002_000A);
    cyc();
    if_abort = 1'b0;
    smp();
    check("fresh_mem_req", 32'(mem_req), 32'd1);
    check("fresh_mem_addr", 32'(mem_addr), 32'h004);
    wait_done(1'b0, 10);
    cyc();
    if_req = 1'b0;

    // Abort in the very cycle mem_rdy is sampled
    run_abort(1, 2, 32'h2002_000A);

    // Starvation: four data grants, then fetch, then data again
    cyc();
    if_req = 1'b1; if_addr = 9'h008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; mem_w = 0;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 32'hDEAD_BEEF);
    push(1'b0, 1'b1, 32'h1111_0008);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) wait_done(1'b1, 10);
    check("starve_cnt_max", 32'(dut.starve_cnt), 32'd4);
    cyc(); smp();
    check("starve_fetch_req", 32'(mem_req), 32'd1);
    check("starve_fetch_addr", 32'(mem_addr), 32'h008);
    wait_done(1'b0, 10);
    check("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
    cyc();
    if_req = 1'b0;
    wait_done(1'b1, 10);
    cyc();
    d_req = 1'b0;

    // Reset during BUSY_D wait cycles
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; mem_w = 3;
    cyc(); smp();
    check("rstmid_mem_req_before", 32'(mem_req), 32'd1);
    cyc();
    rst = 1'b1; d_req = 1'b0;
    #1;
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    check("rstmid_d_rdata", d_rdata, 32'd0);
    check("rstmid_if_inst", if_inst, 32'd0);
    check("rstmid_d_done", 32'(d_done), 32'd0);
    cyc();
    rst = 1'b0;
    repeat (8) smp();
    check("rstmid_idle_after", 32'(mem_req), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning byte address width, matching the PC width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants while a fetch waits.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 if_req  in  1  fetch request from the IF stage, held until if_done.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_abort  in  1  flush of the in-flight fetch (taken branch or jump).
REQ-009 if_done  out  1  one-cycle pulse; if_inst is valid.
REQ-010 if_inst  out  DATA_W  fetched instruction.
REQ-011 d_req  in  1  data request from the MEM stage, held until d_done.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_done  out  1  one-cycle pulse; the access is complete and d_rdata is valid for loads.
REQ-016 d_rdata  out  DATA_W  load data.
REQ-017 stall  out  1  pipeline stall, equivalent to the top-level stall net.
REQ-018 mem_req, mem_we, mem_addr, mem_wdata  out  1/1/ADDR_W/DATA_W  request to the single-port unified memory.
REQ-019 mem_rdy  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-020 mem_rdata  in  DATA_W  memory read data.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY_IF and BUSY_D.
REQ-022 Arbitration in IDLE SHALL follow these rules:
- d_req alone: grant data.
- if_req alone: grant fetch.
- Both pending: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
REQ-023 A grant SHALL register the winner's address, we and wdata into the mem_* outputs, assert mem_req on the next cycle, and enter the matching BUSY state.
REQ-024 In a BUSY state, mem_req and all mem_* outputs SHALL hold stable until the cycle mem_rdy=1 is sampled.
REQ-025 On mem_rdy in BUSY_D, the block SHALL do all of the following:
- Register mem_rdata into d_rdata.
- Pulse d_done on the next cycle.
- Increment starve_cnt if if_req=1, saturating at STARVE_MAX; otherwise clear it.
REQ-026 On mem_rdy in BUSY_IF, the block SHALL register mem_rdata into if_inst, pulse if_done on the next cycle, and clear starve_cnt.
REQ-027 After mem_rdy the FSM SHALL return to IDLE, so the minimum spacing between grants is 2 cycles.
REQ-028 Latency SHALL be as follows:
- The request is sampled in IDLE at cycle N.
- mem_req is asserted at N+1.
- With mem_rdy at N+1+W, done pulses at N+2+W, where W is the number of memory wait cycles (W ≥ 0).
REQ-029 In the cycle its done pulses, a requester's req SHALL be ignored so that no stale re-grant occurs.
REQ-030 Fetch abort SHALL behave as follows:
- if_abort while in BUSY_IF, or in the cycle mem_rdy is sampled there: the memory transaction completes, but if_done is suppressed and if_inst is not updated.
- if_abort while a fetch is only pending: no effect.
REQ-031 stall SHALL equal (if_req & ~if_done) | (d_req & ~d_done), evaluated combinationally.
REQ-032 A store SHALL never be aborted, and d_wdata SHALL be latched only at grant.
REQ-033 Simultaneous if_abort and a new if_req in IDLE SHALL be treated as a fresh request.

Reset
REQ-034 While rst=1, all of the following SHALL hold:
- State is IDLE; starve_cnt = 0; abort flag = 0.
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- if_done = 0, d_done = 0, if_inst = 0, d_rdata = 0.
REQ-035 rst asserted mid-transaction SHALL drop mem_req immediately, and no done SHALL pulse after rst is released.
REQ-036 After reset release, the first grant SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-037 Lone fetch: if_addr=0x004, W=0, mem_rdata=0x2002000A -> mem_req at N+1; if_done=1 and if_inst=0x2002000A at N+2; stall high in N..N+1.
REQ-038 Contention: if_req and d_req both high in IDLE, W=2 -> data granted first; the fetch is granted in the IDLE cycle after d_done; the data load returns 0xDEADBEEF.
REQ-039 Starvation: d_req re-asserted continuously with if_req held high and STARVE_MAX=4 -> the 5th grant goes to fetch; starve_cnt then reads 0.
REQ-040 Abort: if_abort pulsed in BUSY_IF with W=3 -> mem_req held 4 cycles, if_done never pulses, if_inst unchanged, FSM returns to IDLE.
REQ-041 Store: d_we=1, d_addr=0x010, d_wdata=0x12345678, W=1 -> mem_we=1 and mem_wdata=0x12345678 stable for 2 cycles, then a d_done pulse.
REQ-042 Reset mid-BUSY_D: rst asserted at W-cycle 1 -> mem_req=0 asynchronously, all outputs 0, no d_done after release.
